// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the load/store unit: funct3 width codes,
// the LSU state encoding and request-legality helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Low funct3 bits encode access size for both signed and unsigned forms.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bundle between EX, the load/store unit, writeback and
// the data-memory port. The slave modport is the LSU's view.
interface load_store_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic            req_valid;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            stall;
  logic            done;
  logic            err;
  logic [XLEN-1:0] load_data;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output stall, done, err, load_data, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  stall, done, err, load_data, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_align_ext.sv
// Combinational load formatter: picks the byte/half lane from the read word
// and sign- or zero-extends it according to funct3.
module load_align_ext
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[16 +: 16] : rdata[0 +: 16];
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one access at a time, stalls EX until done.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input logic         clock,
  input logic         nreset,
  load_store_unit_if.slave lsu
);

  lsu_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] load_data_q, load_data_d;

  logic            req_legal;
  logic [1:0]      req_off;
  logic [3:0]      req_strb;
  logic [XLEN-1:0] req_wdata_fmt;
  logic [XLEN-1:0] fmt_data;
  logic            busy;

  load_align_ext #(.XLEN(XLEN)) u_align (
    .rdata  (lsu.mem_rdata),
    .funct3 (funct3_q),
    .offset (off_q),
    .data   (fmt_data)
  );

  always_comb begin
    req_legal = f3_legal(lsu.req_we, lsu.req_funct3);
    req_off   = lsu.req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3_misaligned(lsu.req_funct3, req_off)) req_legal = 1'b0;
`else
    case (lsu.req_funct3[1:0])
      2'b01:   req_off[0] = 1'b0;
      2'b10:   req_off    = 2'b00;
      default: ;
    endcase
`endif
    case (lsu.req_funct3[1:0])
      2'b00: begin
        req_strb      = 4'b0001 << req_off;
        req_wdata_fmt = {4{lsu.req_wdata[7:0]}};
      end
      2'b01: begin
        req_strb      = 4'b0011 << {req_off[1], 1'b0};
        req_wdata_fmt = {2{lsu.req_wdata[15:0]}};
      end
      default: begin
        req_strb      = 4'b1111;
        req_wdata_fmt = lsu.req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: if (lsu.req_valid) begin
        we_d     = lsu.req_we;
        funct3_d = lsu.req_funct3;
        off_d    = req_off;
        addr_d   = {lsu.req_addr[AW-1:2], 2'b00};
        wdata_d  = req_wdata_fmt;
        wstrb_d  = req_strb;
        err_d    = !req_legal;
        state_d  = req_legal ? BUSY : DONE;
      end
      BUSY: if (lsu.mem_ready) begin
        if (!we_q) load_data_d = fmt_data;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of statement order.
    if (!nreset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'd0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy          = (state_q == BUSY);
  assign lsu.mem_req   = busy;
  assign lsu.mem_we    = busy && we_q;
  assign lsu.mem_wstrb = (busy && we_q) ? wstrb_q : 4'b0000;
  assign lsu.mem_addr  = addr_q;
  assign lsu.mem_wdata = wdata_q;
  // Combinational so EX is held in the very cycle it presents the request.
  assign lsu.stall     = ((state_q == IDLE) && lsu.req_valid) || busy;
  assign lsu.done      = (state_q == DONE);
  assign lsu.err       = (state_q == DONE) && err_q;
  assign lsu.load_data = load_data_q;

endmodule
